// File: rtl/memory_stage.sv
// memory_stage: fourth stage of the minuteCore pipeline.
// Performs loads/stores on the data-memory port and forwards results to writeback.
module memory_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int EX_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PC_in,
    input  logic [31:0]       instr_in,
    input  logic [4:0]        opcode_in,
    input  logic [2:0]        funct_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [4:0]        rd_addr_in,
    input  logic [EX_W-1:0]   exception_in,
    input  logic              exception_in_valid,
    input  logic              nop_instr_in,
    input  logic              halt_in,
    input  logic              pipeline_in_valid,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] PC_out,
    output logic [31:0]       instr_out,
    output logic [4:0]        opcode_out,
    output logic [4:0]        rd_addr_out,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_en,
    output logic [EX_W-1:0]   exception_out,
    output logic              exception_out_valid,
    output logic              halt_out,
    output logic              nop_instr_out,
    output logic              pipeline_out_valid
);

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t r_state;
    state_t w_next;
    logic   w_stall;
    logic   w_retire;

    logic              w_is_ld;
    logic              w_is_st;
    logic              w_mem_cand;
    logic              w_aligned;
    logic              w_memop;
    logic              w_misal;
    logic              w_wb_op;
    logic              w_pass_wb;
    logic [EX_W-1:0]   w_misal_code;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_wdata;
    logic [3:0]        w_wstrb;

    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic [4:0]        r_opcode;
    logic [2:0]        r_funct;
    logic [4:0]        r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_store;
    logic              r_halt;

    assign w_is_ld    = (opcode_in == OP_LOAD);
    assign w_is_st    = (opcode_in == OP_STORE);
    assign w_mem_cand = pipeline_in_valid && (w_is_ld || w_is_st)
                        && !exception_in_valid && !nop_instr_in;
    assign w_memop    = w_mem_cand && w_aligned;
    assign w_misal    = w_mem_cand && !w_aligned;
    assign w_misal_code = w_is_ld ? EX_W'(4) : EX_W'(6);
    assign w_pass_wb  = pipeline_in_valid && !exception_in_valid && !w_misal
                        && !nop_instr_in && (rd_addr_in != 5'd0) && w_wb_op;

    always_comb begin
        w_aligned = 1'b1;
        case (funct_in[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = (addr_in[0] == 1'b0);
            default: w_aligned = (addr_in[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        w_wb_op = 1'b0;
        case (opcode_in)
            5'b01100, 5'b00100, 5'b01101, 5'b00101,
            5'b11011, 5'b11001, 5'b00000, 5'b11100: w_wb_op = 1'b1;
            default: w_wb_op = 1'b0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_memop) begin
                    w_next  = S_REQ;
                    w_stall = 1'b1;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (dmem_gnt) begin
                    if (r_store) begin
                        w_next   = S_IDLE;
                        w_stall  = 1'b0;
                        w_retire = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_stall = !dmem_rvalid;
                if (dmem_rvalid) begin
                    w_next   = S_IDLE;
                    w_retire = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Reset must pull the upstream hold down even while a memop sits at the input.
    assign stall_out = w_stall && !reset;
    assign dmem_req  = (r_state == S_REQ);
    assign dmem_we   = r_store;
    assign dmem_addr = {r_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        w_wdata = r_data;
        w_wstrb = 4'b1111;
        case (r_funct[1:0])
            2'b00: begin
                w_wdata = {4{r_data[7:0]}};
                w_wstrb = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{r_data[15:0]}};
                w_wstrb = 4'b0011 << r_addr[1:0];
            end
            default: begin
                w_wdata = r_data;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    assign dmem_wdata = r_store ? w_wdata : '0;
    assign dmem_wstrb = r_store ? w_wstrb : 4'b0000;

    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = dmem_rdata[7:0];
            2'd1: w_byte = dmem_rdata[15:8];
            2'd2: w_byte = dmem_rdata[23:16];
            2'd3: w_byte = dmem_rdata[31:24];
            default: w_byte = dmem_rdata[7:0];
        endcase
    end

    assign w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_load_data = dmem_rdata;
        case (r_funct)
            3'b000:  w_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(DATA_W-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(DATA_W-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(DATA_W-16){1'b0}}, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= '0;
            r_instr  <= '0;
            r_opcode <= '0;
            r_funct  <= '0;
            r_rd     <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_store  <= 1'b0;
            r_halt   <= 1'b0;
        end else if (r_state == S_IDLE && w_memop) begin
            r_pc     <= PC_in;
            r_instr  <= instr_in;
            r_opcode <= opcode_in;
            r_funct  <= funct_in;
            r_rd     <= rd_addr_in;
            r_addr   <= addr_in;
            r_data   <= result_in;
            r_store  <= w_is_st;
            r_halt   <= halt_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_out              <= '0;
            instr_out           <= '0;
            opcode_out          <= '0;
            rd_addr_out         <= '0;
            wb_data             <= '0;
            wb_en               <= 1'b0;
            exception_out       <= '0;
            exception_out_valid <= 1'b0;
            halt_out            <= 1'b0;
            nop_instr_out       <= 1'b0;
            pipeline_out_valid  <= 1'b0;
        end else begin
            pipeline_out_valid <= 1'b0;
            wb_en              <= 1'b0;
            if (r_state == S_IDLE && !w_memop) begin
                PC_out              <= PC_in;
                instr_out           <= instr_in;
                opcode_out          <= opcode_in;
                rd_addr_out         <= rd_addr_in;
                wb_data             <= result_in;
                wb_en               <= w_pass_wb;
                exception_out       <= w_misal ? w_misal_code : exception_in;
                exception_out_valid <= exception_in_valid || w_misal;
                halt_out            <= halt_in;
                nop_instr_out       <= nop_instr_in;
                pipeline_out_valid  <= pipeline_in_valid;
            end else if (w_retire) begin
                PC_out              <= r_pc;
                instr_out           <= r_instr;
                opcode_out          <= r_opcode;
                rd_addr_out         <= r_rd;
                wb_data             <= r_store ? r_data : w_load_data;
                wb_en               <= !r_store && (r_rd != 5'd0);
                exception_out       <= '0;
                exception_out_valid <= 1'b0;
                halt_out            <= r_halt;
                nop_instr_out       <= 1'b0;
                pipeline_out_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized instruction stream and memory responder,
// checked every cycle against a spec-level model of the memory stage.
`timescale 1ns/1ps
module tb_memory_stage;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    typedef struct {
        logic        valid;
        logic [4:0]  op;
        logic [2:0]  f;
        logic [31:0] res;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        exv;
        logic [3:0]  exc;
        logic        nop;
        logic        halt;
    } ins_t;

    typedef struct {
        logic        pov;
        logic        wb_en;
        logic        chk_data;
        logic [31:0] wb_data;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic        exv;
        logic [3:0]  exc;
        logic        halt;
    } out_t;

    logic clk = 1'b0;
    logic reset;
    logic [31:0] PC_in, instr_in, result_in, addr_in;
    logic [4:0]  opcode_in, rd_addr_in;
    logic [2:0]  funct_in;
    logic [3:0]  exception_in;
    logic        exception_in_valid, nop_instr_in, halt_in, pipeline_in_valid;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] PC_out, instr_out, wb_data;
    logic [4:0]  opcode_out, rd_addr_out;
    logic        wb_en;
    logic [3:0]  exception_out;
    logic        exception_out_valid, halt_out, nop_instr_out, pipeline_out_valid;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .reset(reset),
        .PC_in(PC_in), .instr_in(instr_in), .opcode_in(opcode_in),
        .funct_in(funct_in), .result_in(result_in), .addr_in(addr_in),
        .rd_addr_in(rd_addr_in), .exception_in(exception_in),
        .exception_in_valid(exception_in_valid), .nop_instr_in(nop_instr_in),
        .halt_in(halt_in), .pipeline_in_valid(pipeline_in_valid),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .PC_out(PC_out), .instr_out(instr_out), .opcode_out(opcode_out),
        .rd_addr_out(rd_addr_out), .wb_data(wb_data), .wb_en(wb_en),
        .exception_out(exception_out), .exception_out_valid(exception_out_valid),
        .halt_out(halt_out), .nop_instr_out(nop_instr_out),
        .pipeline_out_valid(pipeline_out_valid)
    );

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    logic        e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    out_t        n_o, o_o;

    int          n_stall = 0;
    int          n_req = 0;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic aligned(input logic [2:0] f, input logic [31:0] a);
        if (f[1:0] == 2'b00) return 1'b1;
        if (f[1:0] == 2'b01) return a[0] == 1'b0;
        return a[1:0] == 2'b00;
    endfunction

    function automatic logic wb_op(input logic [4:0] op);
        return op inside {5'b01100, 5'b00100, 5'b01101, 5'b00101,
                          5'b11011, 5'b11001, 5'b00000, 5'b11100};
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] w;
        w = rd >> (8 * int'(a[1:0]));
        case (f)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] strb(input logic [2:0] f, input logic [31:0] a);
        if (f[1:0] == 2'b00) return 4'(1 << a[1:0]);
        if (f[1:0] == 2'b01) return 4'(3 << a[1:0]);
        return 4'hF;
    endfunction

    function automatic logic [31:0] wdat(input logic [2:0] f, input logic [31:0] d);
        if (f[1:0] == 2'b00) return {4{d[7:0]}};
        if (f[1:0] == 2'b01) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic ins_t mk(input logic v, input logic [4:0] op, input logic [2:0] f,
                                input logic [31:0] res, input logic [31:0] a,
                                input logic [4:0] rd);
        ins_t i;
        i.valid = v; i.op = op; i.f = f; i.res = res; i.addr = a; i.rd = rd;
        i.pc = 32'h0000_4000 + {22'h0, rd, 5'h0}; i.instr = 32'h0BAD_0000 | res;
        i.exv = 1'b0; i.exc = 4'h0; i.nop = 1'b0; i.halt = 1'b0;
        return i;
    endfunction

    always @(posedge clk) begin
        o_o = n_o;
        if (reset) begin
            o_o.pov = 1'b0;
            o_o.wb_en = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (stall_out) n_stall++;
        if (dmem_req) begin
            n_req++;
            s_we = dmem_we; s_addr = dmem_addr;
            s_wdata = dmem_wdata; s_wstrb = dmem_wstrb;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_out", stall_out, e_stall);
            chk("dmem_req", dmem_req, e_req);
            if (e_req) begin
                chk("dmem_addr", dmem_addr, e_addr);
                chk("dmem_we", dmem_we, e_we);
                chk("dmem_wstrb", dmem_wstrb, e_wstrb);
                if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
            end
            chk("pipeline_out_valid", pipeline_out_valid, o_o.pov);
            chk("wb_en", wb_en, o_o.wb_en);
            if (o_o.pov) begin
                chk("PC_out", PC_out, o_o.pc);
                chk("instr_out", instr_out, o_o.instr);
                chk("opcode_out", opcode_out, o_o.op);
                chk("rd_addr_out", rd_addr_out, o_o.rd);
                chk("halt_out", halt_out, o_o.halt);
                chk("exception_out_valid", exception_out_valid, o_o.exv);
                if (o_o.exv) chk("exception_out", exception_out, o_o.exc);
                if (o_o.chk_data) chk("wb_data", wb_data, o_o.wb_data);
            end
        end
    end

    task automatic apply(input ins_t i);
        pipeline_in_valid = i.valid; opcode_in = i.op; funct_in = i.f;
        result_in = i.res; addr_in = i.addr; PC_in = i.pc; instr_in = i.instr;
        rd_addr_in = i.rd; exception_in_valid = i.exv; exception_in = i.exc;
        nop_instr_in = i.nop; halt_in = i.halt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input ins_t i, input int gw, input int rw, input logic [31:0] rdat);
        logic ld, st, mem;
        out_t r, idle;
        apply(i);
        ld = (i.op == OP_LOAD);
        st = (i.op == OP_STORE);
        mem = i.valid && (ld || st) && !i.exv && !i.nop;
        r.pc = i.pc; r.instr = i.instr; r.op = i.op; r.rd = i.rd; r.halt = i.halt;
        idle = r;
        idle.pov = 1'b0; idle.wb_en = 1'b0; idle.chk_data = 1'b0;
        idle.wb_data = 32'h0; idle.exv = 1'b0; idle.exc = 4'h0;
        if (!(mem && aligned(i.f, i.addr))) begin
            r.pov = i.valid; r.chk_data = 1'b1; r.wb_data = i.res;
            r.exv = i.exv || mem;
            r.exc = mem ? (ld ? 4'd4 : 4'd6) : i.exc;
            r.wb_en = i.valid && !r.exv && !i.nop && (i.rd != 0) && wb_op(i.op);
            e_stall = 1'b0; e_req = 1'b0; n_o = r;
            dmem_gnt = 1'($urandom_range(0, 1));
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            tick();
            return;
        end
        e_stall = 1'b1; e_req = 1'b0; n_o = idle;
        dmem_gnt = 1'($urandom_range(0, 1));
        dmem_rvalid = 1'($urandom_range(0, 1));
        tick();
        e_req = 1'b1; e_we = st;
        e_addr = {i.addr[31:2], 2'b00};
        e_wstrb = st ? strb(i.f, i.addr) : 4'h0;
        e_wdata = wdat(i.f, i.res);
        for (int k = 0; k <= gw; k++) begin
            dmem_gnt = (k == gw);
            dmem_rvalid = (k == gw) ? 1'b0 : 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            if (k == gw && st) begin
                r.pov = 1'b1; r.exv = 1'b0; r.exc = 4'h0;
                r.chk_data = 1'b0; r.wb_data = 32'h0; r.wb_en = 1'b0;
                e_stall = 1'b0; n_o = r;
            end else begin
                e_stall = 1'b1; n_o = idle;
            end
            tick();
        end
        if (st) return;
        e_req = 1'b0;
        for (int k = 0; k <= rw; k++) begin
            dmem_gnt = 1'($urandom_range(0, 1));
            dmem_rvalid = (k == rw);
            dmem_rdata = (k == rw) ? rdat : $urandom;
            if (k == rw) begin
                r.pov = 1'b1; r.exv = 1'b0; r.exc = 4'h0; r.chk_data = 1'b1;
                r.wb_data = load_val(i.f, i.addr, rdat);
                r.wb_en = (i.rd != 0);
                e_stall = 1'b0; n_o = r;
            end else begin
                e_stall = 1'b1; n_o = idle;
            end
            tick();
        end
        dmem_rvalid = 1'b0;
    endtask

    function automatic ins_t rand_ins();
        logic [4:0] alu_ops [9];
        logic [2:0] ld_f [5];
        ins_t i;
        int kind;
        alu_ops = '{5'b01100, 5'b00100, 5'b01101, 5'b00101, 5'b11011,
                    5'b11001, 5'b11100, 5'b11000, 5'b00011};
        ld_f = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        i = mk(1'b1, alu_ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
               $urandom, $urandom, 5'($urandom_range(0, 31)));
        i.pc = $urandom; i.instr = $urandom; i.exc = 4'($urandom);
        i.halt = ($urandom_range(0, 7) == 0);
        kind = $urandom_range(0, 9);
        case (kind)
            3: begin
                i.valid = 1'b0;
                if ($urandom_range(0, 1) == 1) i.op = OP_LOAD;
            end
            4: begin
                i.exv = 1'b1;
                i.op = $urandom_range(0, 1) ? OP_LOAD : OP_STORE;
            end
            5: begin
                i.nop = 1'b1;
                i.op = $urandom_range(0, 1) ? OP_LOAD : OP_STORE;
            end
            6, 7, 8: begin
                i.op = (kind == 8) ? OP_STORE : OP_LOAD;
                i.f = (kind == 8) ? 3'($urandom_range(0, 2)) : ld_f[$urandom_range(0, 4)];
                if (i.f[1:0] == 2'b01) i.addr[0] = 1'b0;
                if (i.f[1:0] == 2'b10) i.addr[1:0] = 2'b00;
            end
            9: begin
                i.op = $urandom_range(0, 1) ? OP_LOAD : OP_STORE;
                i.f = $urandom_range(0, 1) ? 3'b001 : 3'b010;
                if (i.f == 3'b001) i.addr[0] = 1'b1;
                else i.addr[1:0] = 2'($urandom_range(1, 3));
            end
            default: ;
        endcase
        return i;
    endfunction

    initial begin
        int s0, q0;
        out_t z;
        reset = 1'b1;
        apply(mk(1'b0, 5'b0, 3'b0, 32'h0, 32'h0, 5'd0));
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        z = '{pov: 1'b0, wb_en: 1'b0, chk_data: 1'b0, wb_data: 32'h0, pc: 32'h0,
              instr: 32'h0, op: 5'h0, rd: 5'h0, exv: 1'b0, exc: 4'h0, halt: 1'b0};
        n_o = z; o_o = z;
        e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0;
        e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;
        repeat (2) tick();
        chk("rst_pov", pipeline_out_valid, 1'b0);
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", stall_out, 1'b0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_exv", exception_out_valid, 1'b0);
        reset = 1'b0;
        tick();
        chk_en = 1'b1;

        s0 = n_stall;
        run(mk(1'b1, 5'b01100, 3'b000, 32'h1234, 32'h0, 5'd5), 0, 0, 32'h0);
        chk("lit_add_wb_data", wb_data, 32'h1234);
        chk("lit_add_wb_en", wb_en, 1'b1);
        chk("lit_add_pov", pipeline_out_valid, 1'b1);
        chk("lit_add_stall", 32'(n_stall - s0), 32'd0);

        s0 = n_stall;
        run(mk(1'b1, OP_LOAD, 3'b010, 32'h0, 32'h100, 5'd7), 0, 2, 32'hDEADBEEF);
        chk("lit_lw_addr", s_addr, 32'h100);
        chk("lit_lw_wb_data", wb_data, 32'hDEADBEEF);
        chk("lit_lw_stall_cycles", 32'(n_stall - s0), 32'd4);

        run(mk(1'b1, OP_LOAD, 3'b000, 32'h0, 32'h103, 5'd8), 1, 0, 32'h80FF_FFFF);
        chk("lit_lb_wb_data", wb_data, 32'hFFFFFF80);
        run(mk(1'b1, OP_LOAD, 3'b100, 32'h0, 32'h103, 5'd8), 0, 1, 32'h80FF_FFFF);
        chk("lit_lbu_wb_data", wb_data, 32'h00000080);

        run(mk(1'b1, OP_STORE, 3'b001, 32'h0000ABCD, 32'h102, 5'd9), 1, 0, 32'h0);
        chk("lit_sh_we", s_we, 1'b1);
        chk("lit_sh_addr", s_addr, 32'h100);
        chk("lit_sh_wstrb", s_wstrb, 4'b1100);
        chk("lit_sh_wdata", s_wdata, 32'hABCDABCD);
        chk("lit_sh_wb_en", wb_en, 1'b0);

        q0 = n_req;
        run(mk(1'b1, OP_LOAD, 3'b010, 32'h55, 32'h1001, 5'd3), 0, 0, 32'h0);
        chk("lit_mis_req", 32'(n_req - q0), 32'd0);
        chk("lit_mis_exc", exception_out, 4'd4);
        chk("lit_mis_exv", exception_out_valid, 1'b1);
        chk("lit_mis_wb_en", wb_en, 1'b0);
        chk("lit_mis_pov", pipeline_out_valid, 1'b1);

        for (int n = 0; n < 400; n++)
            run(rand_ins(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);

        chk_en = 1'b0;
        n_o = z;
        apply(mk(1'b1, OP_LOAD, 3'b010, 32'h0, 32'h200, 5'd4));
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        tick();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        chk("wait_stall_before_rst", stall_out, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_req", dmem_req, 1'b0);
        chk("rst_async_stall", stall_out, 1'b0);
        chk("rst_async_pov", pipeline_out_valid, 1'b0);
        tick();
        reset = 1'b0;
        apply(mk(1'b0, 5'b01100, 3'b0, 32'h0, 32'h0, 5'd0));
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h1111_2222;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_pov", pipeline_out_valid, 1'b0);
            chk("post_rst_req", dmem_req, 1'b0);
            chk("post_rst_stall", stall_out, 1'b0);
        end
        dmem_rvalid = 1'b0;
        run(mk(1'b1, 5'b00100, 3'b0, 32'hCAFE_0001, 32'h0, 5'd6), 0, 0, 32'h0);
        chk("post_rst_add_pov", pipeline_out_valid, 1'b1);
        chk("post_rst_add_wb", wb_data, 32'hCAFE_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
